// File: rtl/serial_rx_msg_pkg.sv
// Shared serial definitions: default bit period, byte FSM encoding, byte
// result payload and the counter-width helper used by RX and TX sides.
package serial_rx_msg_pkg;

    localparam int unsigned CLK_PER_BIT_DEF = 50;
    localparam int unsigned BYTE_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } byte_state_e;

    // Outcome of one deserialized frame; valid/err are single-cycle strobes.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              valid;
        logic              err;
    } rx_byte_t;

    // Bits needed to hold values 0..value-1, never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_rx_msg_if.sv
// Pin-side serial input and message-side outputs of the message receiver.
interface serial_rx_msg_if #(
    parameter int unsigned MSG_LEN = 4
);
    logic                   rx;
    logic [8*MSG_LEN-1:0]   msg;
    logic                   new_msg;
    logic                   frame_err;

    modport master (input rx, output msg, output new_msg, output frame_err);
    modport slave  (output rx, input msg, input new_msg, input frame_err);
endinterface

// File: rtl/serial_rx_byte.sv
// 8N1 byte deserializer: input synchronizer, byte FSM, baud and bit counters.
// Result strobes are combinational so the caller can register them on the stop sample.
module serial_rx_byte
    import serial_rx_msg_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rx,
    output rx_byte_t res_c,
    output logic     idle_c,
    output logic     start_ok_c
);

    localparam int unsigned CNT_W = clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

    logic              rx_meta;
    logic              rx_s;
    byte_state_e       state;
    byte_state_e       state_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_d;
    logic [BYTE_W-1:0] shift;
    logic [BYTE_W-1:0] shift_d;

    // Two-flop synchronizer, reset to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
        end
    end

    // Next state, counters and result strobes; sampling happens at mid-bit.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 1'b1;
        bit_d      = bit_idx;
        shift_d    = shift;
        res_c      = '0;
        res_c.data = shift;
        idle_c     = (state == ST_IDLE);
        start_ok_c = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_DATA;
                        bit_d      = '0;
                        start_ok_c = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift[BYTE_W-1:1]};
                    bit_d   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                    res_c.valid = rx_s;
                    res_c.err   = !rx_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/serial_rx_msg.sv
// Assembles MSG_LEN received bytes into one message; first byte lands in the
// low byte. Partial messages are dropped on a framing error or idle timeout.
module serial_rx_msg
    import serial_rx_msg_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF,
    parameter int unsigned MSG_LEN     = 4,
    parameter int unsigned MSG_BITS    = 2,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic              clk,
    input  logic              rst,
    serial_rx_msg_if.master   bus
);

    localparam int unsigned TO_W = clog2(TIMEOUT + 1);
    localparam logic [MSG_BITS-1:0] LAST_SLOT = MSG_BITS'(MSG_LEN - 1);
    localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT);

    rx_byte_t                       res_c;
    logic                           idle_c;
    logic                           start_ok_c;
    logic [MSG_LEN-1:0][BYTE_W-1:0] slot;
    logic [MSG_LEN-1:0][BYTE_W-1:0] word_c;
    logic [MSG_LEN-1:0][BYTE_W-1:0] msg_q;
    logic [MSG_BITS-1:0]            byte_cnt;
    logic [TO_W-1:0]                idle_cnt;
    logic                           new_msg_q;
    logic                           frame_err_q;

    serial_rx_byte #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_byte (
        .clk        (clk),
        .rst        (rst),
        .rx         (bus.rx),
        .res_c      (res_c),
        .idle_c     (idle_c),
        .start_ok_c (start_ok_c)
    );

    // Completed word: stored slots plus the byte arriving right now on top.
    always_comb begin
        word_c            = slot;
        word_c[MSG_LEN-1] = res_c.data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot        <= '0;
            msg_q       <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            new_msg_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            new_msg_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (res_c.err) begin
                frame_err_q <= 1'b1;
                byte_cnt    <= '0;
            end else if (res_c.valid) begin
                if (byte_cnt == LAST_SLOT) begin
                    msg_q     <= word_c;
                    new_msg_q <= 1'b1;
                    byte_cnt  <= '0;
                end else begin
                    slot[byte_cnt] <= res_c.data;
                    byte_cnt       <= byte_cnt + 1'b1;
                end
            end else if (idle_c && (byte_cnt != '0)) begin
                // A stalled partial message is abandoned after TIMEOUT idle clocks.
                if (idle_cnt == TO_LAST) begin
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
            if (start_ok_c) begin
                idle_cnt <= '0;
            end
        end
    end

    assign bus.msg       = msg_q;
    assign bus.new_msg   = new_msg_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: doc/serial_rx_msg.md
# serial_rx_msg

Receive-side counterpart of the UART message transmitter. Deserializes 8N1 bytes from the `rx` pin and assembles `MSG_LEN` consecutive bytes into one `8*MSG_LEN`-bit message. Presents the message with a single-cycle `new_msg` strobe. Sits at the FPGA pin boundary, feeding command decoders that consume fixed-length host messages.

## Interface
Parameters:
- `CLK_PER_BIT`, default 50: clocks per UART bit; 1 Mbaud at 50 MHz. Must be ≥ 4 and even.
- `MSG_LEN`, default 4: bytes per message.
- `MSG_BITS`, default 2: width of the byte counter; `2**MSG_BITS >= MSG_LEN`.
- `TIMEOUT`, default 1000: idle clocks after which a partial message is discarded.

Ports:
- `clk`, in, 1: sole clock, rising-edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: asynchronous serial input; idles high.
- `msg`, out, `8*MSG_LEN`: last complete message. First received byte is in `msg[7:0]`, last in the top byte.
- `new_msg`, out, 1: one-cycle strobe when `msg` updates.
- `frame_err`, out, 1: one-cycle strobe on a bad stop bit.

## Operation
- `rx` passes through a 2-FF synchronizer; all logic uses the synchronized value `rx_s`.
- Byte FSM states:
  - IDLE: waits for `rx_s==0`.
  - START: counts `CLK_PER_BIT/2`. If `rx_s` is still 0, goes to DATA; if it is 1, the low was a glitch and the FSM returns to IDLE with no error.
  - DATA: samples 8 bits, LSB first, each `CLK_PER_BIT` clocks apart.
  - STOP: samples one bit `CLK_PER_BIT` later. If 1, the byte is valid. If 0, `frame_err` pulses and the byte is dropped. The FSM returns to IDLE in both cases.
- Message assembler:
  - Each valid byte is written into the shift/slot register at index `byte_cnt`, then `byte_cnt` increments.
  - When `byte_cnt` reaches `MSG_LEN-1` and that byte is valid: `msg` loads the full assembled word in parallel, `new_msg` pulses, and `byte_cnt` returns to 0.
  - A framing error resets `byte_cnt` to 0 and discards the partial message. `msg` is unchanged.
- Timeout:
  - The idle counter runs while the FSM is in IDLE and `byte_cnt != 0`.
  - When it reaches `TIMEOUT`, `byte_cnt` clears with no strobe.
  - The counter clears whenever a start bit is accepted.
- `msg` holds its value until the next complete message. There is no back-pressure; the consumer must take `msg` on the strobe or later.
- A low `rst` at any time, including mid-byte or mid-message, immediately clears all state. Reset values: `msg`=0, `new_msg`=0, `frame_err`=0, FSM in IDLE, `byte_cnt`=0, synchronizer flops = 1.

## Timing
- t0 is the first rising edge at which `rx_s==0` in IDLE. t0 is 2 clocks after the pin edge.
- Start bit confirmed at t0+`CLK_PER_BIT/2`.
- Data bit i (i = 0..7) sampled at t0+`CLK_PER_BIT/2`+(i+1)·`CLK_PER_BIT`.
- Stop bit sampled at t0+`CLK_PER_BIT/2`+9·`CLK_PER_BIT`.
- `new_msg` and `frame_err` are registered: high for exactly the one cycle after the stop sample. `msg` is valid in that same cycle.
- Back-to-back bytes with no inter-byte gap are accepted. IDLE is re-entered half a bit before the next start edge.
- Tolerates ±4% baud mismatch. The sampling point drifts by no more than ~0.4 bit over 10 bits.

## Structure
- Shared serial package holds:
  - `CLK_PER_BIT` default,
  - byte FSM state encoding (IDLE/START/DATA/STOP), shared with the TX side,
  - the `clog2` helper for counter widths.
- One sub-module, `serial_rx_byte`: synchronizer, byte FSM, bit counter and baud counter. Outputs `data[7:0]`, `valid` and `err` strobes.
- Top level holds `byte_cnt`, the slot register, the timeout counter and the output registers.

## Test plan
Use `CLK_PER_BIT`=8 and `TIMEOUT`=200 for simulation speed.
- Send bytes 0xAA, 0xCC, 0xF0, 0x81 back-to-back → exactly one `new_msg` pulse, `msg`=32'h81F0CCAA; `frame_err` never asserts.
- Send two messages (0x01020304 byte order, then 0xDEADBEEF) with a 3-bit gap between them → two pulses; `msg` is correct after each and held steady between them.
- Send 0x11, 0x22, then idle 300 clocks, then 0x33, 0x44, 0x55, 0x66 → a single pulse, `msg`=32'h66554433.
- Send 0x11, then 0x22 with the stop bit forced to 0, then four good bytes 0xA0–0xA3 → one `frame_err` pulse; `msg`=32'hA3A2A1A0.
- Drive a 2-clock low glitch on `rx` → no state change, no strobes, `byte_cnt` stays 0.
- Assert `rst` low midway through the third byte, release, then send 4 bytes → `msg` reads 0 until a `new_msg` pulse carrying the new 4 bytes only.
